vx_task_dispatcher: RTL and testbench
=====================================

Name: vx_task_dispatcher

Overview:
- Credit-based distributor of kernel tasks from one upstream task stream to NUM_OUTPUTS per-core task ports inside a socket.
- Supports unicast dispatch, selected by round-robin or least-loaded policy, and broadcast dispatch to all cores.
- Tracks per-core in-flight tasks through completion pulses and exports socket-level busy.
- Successor to the fixed 1-to-SOCKET_SIZE task arbiter: adds flow control by credits, selectable policy and broadcast.

Parameters:
- NUM_OUTPUTS, 4: number of core task ports, 1..32.
- TASK_WIDTH, 64: task payload width in bits.
- MAX_INFLIGHT, 2: credits per core, i.e. maximum outstanding tasks per core, ≥1.
- POLICY, 0: unicast target selection; 0 = round-robin, 1 = least-loaded.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- in_valid  input  1  upstream task valid.
- in_data  input  TASK_WIDTH  task payload.
- in_bcast  input  1  1 = deliver the task to every output.
- in_ready  output  1  task accepted when in_valid && in_ready.
- out_valid  output  NUM_OUTPUTS  per-core task valid.
- out_data  output  TASK_WIDTH  registered payload, shared by all outputs.
- out_ready  input  NUM_OUTPUTS  per-core accept.
- done  input  NUM_OUTPUTS  one-cycle pulse: core finished one task.
- credits  output  NUM_OUTPUTS*CW  per-core free credits, CW = clog2(MAX_INFLIGHT+1).
- busy  output  1  a task is pending or any core has in-flight work.

Behaviour:
- Reset (reset=0, asynchronous):
  - credits = MAX_INFLIGHT for every core.
  - pending = 0, dest_mask = 0, out_valid = 0, out_data = 0.
  - RR pointer = 0, busy = 0.
- State: one holding register containing {out_data, dest_mask[NUM_OUTPUTS]}; pending = |dest_mask.
- out_valid[i] = dest_mask[i]. Each fire (out_valid[i] && out_ready[i]) clears dest_mask[i] at the next edge.
- Drain: drain = remaining mask after this cycle's fires is zero. in_ready is combinational in out_ready, which allows back-to-back tasks at 1 task/cycle.
- in_ready = (!pending || drain) && avail, where:
  - unicast: avail = any core has credit > 0.
  - broadcast: avail = every core has credit > 0.
- Latency: task accepted at edge N → out_valid at edge N; accepting output fires no earlier than that cycle.
- Unicast target (chosen at acceptance, from registered credits only; same-cycle done is not considered):
  - POLICY 0: first core with credit > 0, searching from the RR pointer upward with wrap. Pointer ← target+1 mod NUM_OUTPUTS.
  - POLICY 1: core with the maximum credit; ties go to the lowest index. RR pointer unused.
- Credit update per core, each cycle: credit += done[i] − granted[i]. granted is set at acceptance, not at out fire.
  - done and grant in the same cycle: credit unchanged.
- Credit saturation: done on a core already at MAX_INFLIGHT is ignored (credit stays MAX) and fires a simulation assertion. Credit never underflows, because grant requires credit > 0.
- Broadcast: dest_mask = all ones and every credit decrements by 1. Cores accept independently in any order. A new task is not accepted until the last core fires.
- out_data is stable while pending. dest_mask bits only clear, never set, until the next acceptance.
- busy = pending || any credit < MAX_INFLIGHT.
- Reset mid-operation: pending task dropped, all credits restored. A done pulse arriving during reset is ignored.
- NUM_OUTPUTS = 1: both policies degenerate to always target 0.

Decomposition:
- Shared package: task_dispatch_policy_e {RR, LEAST_LOADED} and the CW width function, placed with the existing task-bus typedefs.
- One natural sub-module, vx_task_select. Combinational. Inputs: credit vector, RR pointer, policy. Outputs: target one-hot and avail.
- The holding register and credit counters stay in the top block.

Test Plan:
- RR, NUM_OUTPUTS=4, MAX_INFLIGHT=2, all out_ready=1, 8 unicast tasks → targets 0,1,2,3,0,1,2,3 at 1 task/cycle; all credits 0; in_ready=0 afterwards.
- Credit exhaustion: then done[2] pulse → in_ready=1 next cycle; next task goes to core 2; credits[2] back to 0.
- LEAST_LOADED: credits {2,1,2,0}, one task → target core 0 (tie at 2, lowest index); credits become {1,1,2,0}.
- Broadcast, out_ready staggered: cores 3,0 fire at cycle 1, 1 at cycle 3, 2 at cycle 5 → out_data stable; in_ready=0 through cycle 4; next task accepted in cycle 5; every credit decremented by 1.
- Simultaneous grant and done on core 1 at credit 1 → credits[1] stays 1. Done on a core at MAX → stays 2 and the assertion fires.
- reset=0 asynchronously mid-broadcast with 2 bits of dest_mask outstanding → out_valid=0 immediately, credits=MAX, busy=0; first post-reset unicast goes to core 0.

Source files
------------

// File: rtl/vx_task_dispatcher_pkg.sv
// Shared definitions for the socket task dispatcher: policy encoding and
// the helper widths derived from the dispatcher parameters.
package vx_task_dispatcher_pkg;

  // Unicast target selection policy.
  typedef enum logic {
    RR           = 1'b0,
    LEAST_LOADED = 1'b1
  } task_dispatch_policy_e;

  // Width of one per-core credit counter (holds 0..max_inflight).
  function automatic int credit_width(input int max_inflight);
    return $clog2(max_inflight + 1);
  endfunction

  // Width of a core index / round-robin pointer; at least one bit.
  function automatic int ptr_width(input int num_outputs);
    return (num_outputs > 1) ? $clog2(num_outputs) : 1;
  endfunction

endpackage

// File: rtl/vx_task_dispatcher_if.sv
// Task stream bundle between the upstream producer and the per-core task
// ports. The master side is the producer plus the cores; the slave side is
// the dispatcher.
interface vx_task_dispatcher_if #(
  parameter int NUM_OUTPUTS = 4,
  parameter int TASK_WIDTH  = 64
);

  logic                   in_valid;
  logic [TASK_WIDTH-1:0]  in_data;
  logic                   in_bcast;
  logic                   in_ready;
  logic [NUM_OUTPUTS-1:0] out_valid;
  logic [TASK_WIDTH-1:0]  out_data;
  logic [NUM_OUTPUTS-1:0] out_ready;

  modport master (
    output in_valid, in_data, in_bcast, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_bcast, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/vx_task_select.sv
// Combinational unicast target picker. Looks only at registered credits:
// round-robin takes the first core with credit starting at the pointer,
// least-loaded takes the core with the most free credits (lowest index wins
// ties). Also reports whether any / every core can take a task.
module vx_task_select
  import vx_task_dispatcher_pkg::*;
#(
  parameter int NUM_OUTPUTS = 4,
  parameter int CW          = 2,
  parameter int PW          = 2
) (
  input  logic [NUM_OUTPUTS*CW-1:0] i_credits,
  input  logic [PW-1:0]             i_rr_ptr,
  input  task_dispatch_policy_e     i_policy,
  output logic [NUM_OUTPUTS-1:0]    o_target,
  output logic [PW-1:0]             o_target_idx,
  output logic                      o_avail_any,
  output logic                      o_avail_all
);

  logic [NUM_OUTPUTS-1:0] w_has_credit;
  logic [PW-1:0]          w_rr_idx;
  logic [PW-1:0]          w_ll_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_has_credit
      assign w_has_credit[gi] = |i_credits[gi*CW +: CW];
    end
  endgenerate

  assign o_avail_any = |w_has_credit;
  assign o_avail_all = &w_has_credit;

  // Round-robin scan: walk downward so the closest core to the pointer is the last writer.
  always_comb begin : rr_scan
    int            idx;
    logic [PW-1:0] sel;
    w_rr_idx = '0;
    for (int k = NUM_OUTPUTS - 1; k >= 0; k--) begin
      idx = int'(i_rr_ptr) + k;
      if (idx >= NUM_OUTPUTS) idx = idx - NUM_OUTPUTS;
      sel = PW'(idx);
      if (w_has_credit[sel]) w_rr_idx = sel;
    end
  end

  // Least-loaded scan: strict compare keeps the lowest index on ties.
  always_comb begin : ll_scan
    logic [CW-1:0] best;
    w_ll_idx = '0;
    best     = i_credits[CW-1:0];
    for (int i = 1; i < NUM_OUTPUTS; i++) begin
      if (i_credits[i*CW +: CW] > best) begin
        best     = i_credits[i*CW +: CW];
        w_ll_idx = PW'(i);
      end
    end
  end

  assign o_target_idx = (i_policy == LEAST_LOADED) ? w_ll_idx : w_rr_idx;

  // One-hot target; empty when no core has a credit.
  always_comb begin
    o_target               = '0;
    o_target[o_target_idx] = o_avail_any;
  end

endmodule

// File: rtl/vx_task_dispatcher.sv
// Credit-based task dispatcher: takes tasks from one upstream stream and
// hands them to one core (round-robin or least-loaded) or to all cores
// (broadcast). A single holding register keeps the payload plus a mask of
// cores still to accept it; credits count free task slots per core and are
// returned by done pulses.
module vx_task_dispatcher
  import vx_task_dispatcher_pkg::*;
#(
  parameter  int NUM_OUTPUTS  = 4,
  parameter  int TASK_WIDTH   = 64,
  parameter  int MAX_INFLIGHT = 2,
  parameter  int POLICY       = 0,
  localparam int CW           = credit_width(MAX_INFLIGHT),
  localparam int PW           = ptr_width(NUM_OUTPUTS)
) (
  input  logic                      clk,
  input  logic                      reset,
  vx_task_dispatcher_if.slave       bus,
  input  logic [NUM_OUTPUTS-1:0]    done,
  output logic [NUM_OUTPUTS*CW-1:0] credits,
  output logic                      busy
);

  localparam logic [CW-1:0]         MAX_CREDIT = CW'(MAX_INFLIGHT);
  localparam task_dispatch_policy_e SEL_POLICY = (POLICY == 1) ? LEAST_LOADED : RR;

  logic [TASK_WIDTH-1:0]     r_data;
  logic [NUM_OUTPUTS-1:0]    r_mask;
  logic [CW-1:0]             r_credit [NUM_OUTPUTS];
  logic [PW-1:0]             r_rr_ptr;

  logic [NUM_OUTPUTS*CW-1:0] w_credit_vec;
  logic [NUM_OUTPUTS-1:0]    w_target;
  logic [PW-1:0]             w_target_idx;
  logic                      w_avail_any;
  logic                      w_avail_all;
  logic [NUM_OUTPUTS-1:0]    w_fire;
  logic [NUM_OUTPUTS-1:0]    w_mask_left;
  logic                      w_pending;
  logic                      w_drain;
  logic                      w_avail;
  logic                      w_accept;
  logic [NUM_OUTPUTS-1:0]    w_grant;
  logic                      w_any_used;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_credit_out
      assign w_credit_vec[gi*CW +: CW] = r_credit[gi];
    end
  endgenerate

  assign credits = w_credit_vec;

  vx_task_select #(
    .NUM_OUTPUTS (NUM_OUTPUTS),
    .CW          (CW),
    .PW          (PW)
  ) u_select (
    .i_credits    (w_credit_vec),
    .i_rr_ptr     (r_rr_ptr),
    .i_policy     (SEL_POLICY),
    .o_target     (w_target),
    .o_target_idx (w_target_idx),
    .o_avail_any  (w_avail_any),
    .o_avail_all  (w_avail_all)
  );

  // Acceptance is allowed in the cycle the last outstanding core fires,
  // so in_ready looks through out_ready to keep one task per cycle.
  assign w_pending    = |r_mask;
  assign w_fire       = r_mask & bus.out_ready;
  assign w_mask_left  = r_mask & ~w_fire;
  assign w_drain      = ~|w_mask_left;
  assign w_avail      = bus.in_bcast ? w_avail_all : w_avail_any;
  assign bus.in_ready = (!w_pending || w_drain) && w_avail;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_grant      = !w_accept    ? '0 :
                        bus.in_bcast ? '1 : w_target;

  assign bus.out_valid = r_mask;
  assign bus.out_data  = r_data;

  // Holding register: load on acceptance, otherwise retire fired cores.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
      r_mask <= '0;
    end else if (w_accept) begin
      r_data <= bus.in_data;
      r_mask <= w_grant;
    end else begin
      r_mask <= w_mask_left;
    end
  end

  // Round-robin pointer moves past the core that took the last unicast task.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= '0;
    end else if (w_accept && !bus.in_bcast && (SEL_POLICY == RR)) begin
      r_rr_ptr <= (w_target_idx == PW'(NUM_OUTPUTS - 1)) ? '0 : w_target_idx + PW'(1);
    end
  end

  // Credits: grant takes one, done returns one; both together cancel; a
  // return to a full core is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) r_credit[i] <= MAX_CREDIT;
    end else begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        if (done[i] && !w_grant[i]) begin
          if (r_credit[i] != MAX_CREDIT) r_credit[i] <= r_credit[i] + CW'(1);
        end else if (w_grant[i] && !done[i]) begin
          r_credit[i] <= r_credit[i] - CW'(1);
        end
      end
    end
  end

  // Busy whenever any core holds a credit taken but not yet returned.
  always_comb begin
    w_any_used = 1'b0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      if (r_credit[i] != MAX_CREDIT) w_any_used = 1'b1;
    end
  end

  assign busy = w_pending || w_any_used;

  // A completion pulse from a core with no task in flight points at a core-side bug.
  generate
    for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_overflow_chk
      a_credit_overflow : assert property (@(posedge clk) disable iff (!reset)
        !(done[gi] && !w_grant[gi] && (r_credit[gi] == MAX_CREDIT)))
        else $warning("done on core %0d with every credit already free; pulse ignored", gi);
    end
  endgenerate

endmodule

// File: tb/tb_vx_task_dispatcher.sv
// Scoreboard bench for the task dispatcher. Two instances share stimulus:
// dut0 uses round-robin, dut1 least-loaded. The stimulus process keeps a
// reference model (credit counts, per-core outstanding bits, RR pointer) and
// pushes each accepted task onto per-core expectation queues; the monitor
// pops and compares whenever a core accepts a task.
module tb_vx_task_dispatcher;
  import vx_task_dispatcher_pkg::*;

  localparam int N    = 4;
  localparam int TW   = 64;
  localparam int MAXC = 2;
  localparam int CW   = credit_width(MAXC);

  typedef logic [TW-1:0] data_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid;
  data_t         in_data;
  logic          in_bcast;
  logic [N-1:0]  out_ready;
  logic [N-1:0]  done;
  logic [N*CW-1:0] credits0, credits1;
  logic          busy0, busy1;

  always #5 clk = ~clk;

  vx_task_dispatcher_if #(.NUM_OUTPUTS(N), .TASK_WIDTH(TW)) bus0 ();
  vx_task_dispatcher_if #(.NUM_OUTPUTS(N), .TASK_WIDTH(TW)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_data   = in_data;
  assign bus0.in_bcast  = in_bcast;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_data   = in_data;
  assign bus1.in_bcast  = in_bcast;
  assign bus1.out_ready = out_ready;

  vx_task_dispatcher #(.NUM_OUTPUTS(N), .TASK_WIDTH(TW), .MAX_INFLIGHT(MAXC), .POLICY(0)) dut0 (
    .clk(clk), .reset(rst_n), .bus(bus0), .done(done), .credits(credits0), .busy(busy0));

  vx_task_dispatcher #(.NUM_OUTPUTS(N), .TASK_WIDTH(TW), .MAX_INFLIGHT(MAXC), .POLICY(1)) dut1 (
    .clk(clk), .reset(rst_n), .bus(bus1), .done(done), .credits(credits1), .busy(busy1));

  logic [N-1:0]    ov [2];
  data_t           od [2];
  logic            ir [2];
  logic [N*CW-1:0] cr [2];
  logic            bz [2];
  assign ov[0] = bus0.out_valid; assign ov[1] = bus1.out_valid;
  assign od[0] = bus0.out_data;  assign od[1] = bus1.out_data;
  assign ir[0] = bus0.in_ready;  assign ir[1] = bus1.in_ready;
  assign cr[0] = credits0;       assign cr[1] = credits1;
  assign bz[0] = busy0;          assign bz[1] = busy1;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int           cred [2][N];
  logic [N-1:0] pend [2];
  int           rr;
  data_t        exp_q [2][N][$];

  task automatic check(input string name, input data_t act, input data_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      pend[m] = '0;
      for (int i = 0; i < N; i++) begin
        cred[m][i] = MAXC;
        exp_q[m][i].delete();
      end
    end
    rr = 0;
  endtask

  // Target a unicast task would get in model m (-1 when no core has credit).
  function automatic int pick(input int m);
    int best = -1;
    int bv   = 0;
    if (m == 0) begin
      for (int k = 0; k < N; k++) begin
        int c = (rr + k) % N;
        if (cred[0][c] > 0) return c;
      end
      return -1;
    end
    for (int i = 0; i < N; i++) begin
      if (cred[1][i] > bv) begin
        bv   = cred[1][i];
        best = i;
      end
    end
    return best;
  endfunction

  // One clock cycle of stimulus; entered and left at posedge+1.
  task automatic step(input logic v, input data_t d, input logic b,
                      input logic [N-1:0] rdy, input logic [N-1:0] dn);
    logic [N-1:0] grant [2];
    logic         acc   [2];
    in_valid  = v;
    in_data   = d;
    in_bcast  = b;
    out_ready = rdy;
    done      = dn;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      logic any_c, all_c, used, exp_rdy;
      int   t;
      any_c = 1'b0; all_c = 1'b1; used = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (cred[m][i] > 0) any_c = 1'b1; else all_c = 1'b0;
        if (cred[m][i] < MAXC) used = 1'b1;
        check($sformatf("dut%0d credit%0d", m, i), data_t'(cr[m][i*CW +: CW]), data_t'(cred[m][i]));
      end
      check($sformatf("dut%0d busy", m), data_t'(bz[m]), data_t'((pend[m] != 0) || used));
      exp_rdy = ((pend[m] & ~rdy) == '0) && (b ? all_c : any_c);
      check($sformatf("dut%0d in_ready", m), data_t'(ir[m]), data_t'(exp_rdy));
      acc[m]   = v && exp_rdy;
      t        = pick(m);
      grant[m] = '0;
      if (acc[m]) begin
        if (b) grant[m] = '1;
        else   grant[m][t] = 1'b1;
      end
      pend[m] = acc[m] ? grant[m] : (pend[m] & ~rdy);
      for (int i = 0; i < N; i++) begin
        if (dn[i] && !grant[m][i]) begin
          if (cred[m][i] < MAXC) cred[m][i]++;
        end else if (grant[m][i] && !dn[i]) begin
          cred[m][i]--;
        end
      end
      if (m == 0 && acc[m] && !b) rr = (t + 1) % N;
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++)
      if (acc[m])
        for (int i = 0; i < N; i++)
          if (grant[m][i]) exp_q[m][i].push_back(d);
    #1;
  endtask

  // Return credits until both models are full again, draining any holdover.
  task automatic refill();
    for (int r = 0; r < MAXC + 1; r++) begin
      logic [N-1:0] dn = '0;
      for (int i = 0; i < N; i++)
        if (cred[0][i] < MAXC && cred[1][i] < MAXC) dn[i] = 1'b1;
      step(1'b0, '0, 1'b0, '1, dn);
    end
  endtask

  // Monitor: every accepted task must match the head of its core's queue.
  initial begin
    bit has;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int m = 0; m < 2; m++) begin
          for (int i = 0; i < N; i++) begin
            has = (exp_q[m][i].size() != 0);
            check($sformatf("dut%0d out_valid%0d", m, i), data_t'(ov[m][i]), data_t'(has));
            if (ov[m][i] && has) begin
              check($sformatf("dut%0d out_data core%0d", m, i), od[m], exp_q[m][i][0]);
              if (out_ready[i]) begin
                $display("[%0t] dut%0d core%0d accepted task %016h", $time, m, i, od[m]);
                void'(exp_q[m][i].pop_front());
              end
            end
          end
        end
      end
    end
  end

  initial begin
    logic [N*CW-1:0] full;
    logic [N-1:0]    dn;
    data_t           rd;
    for (int i = 0; i < N; i++) full[i*CW +: CW] = CW'(MAXC);
    in_valid = 1'b0; in_data = '0; in_bcast = 1'b0; out_ready = '0; done = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("dut%0d reset out_valid", m), data_t'(ov[m]), '0);
      check($sformatf("dut%0d reset out_data", m), od[m], '0);
      check($sformatf("dut%0d reset credits", m), data_t'(cr[m]), data_t'(full));
      check($sformatf("dut%0d reset busy", m), data_t'(bz[m]), '0);
    end
    rst_n = 1'b1;

    // Eight back-to-back unicast tasks exhaust every credit; the ninth stalls.
    for (int k = 0; k < 8; k++) step(1'b1, data_t'(64'hA000 + k), 1'b0, '1, '0);
    step(1'b1, 64'hA008, 1'b0, '1, '0);
    // One credit back on core 2 opens exactly one slot.
    step(1'b1, 64'hB000, 1'b0, '1, 4'b0100);
    step(1'b1, 64'hB000, 1'b0, '1, '0);
    step(1'b0, '0, 1'b0, '1, '0);

    // Shape credits to {2,1,2,0}; least-loaded picks core 0 on the tie.
    step(1'b0, '0, 1'b0, '1, 4'b0111);
    step(1'b0, '0, 1'b0, '1, 4'b0101);
    step(1'b1, 64'hC000, 1'b0, '1, '0);
    step(1'b0, '0, 1'b0, '1, '0);

    // Broadcast with staggered acceptance; a queued unicast waits for the last core.
    refill();
    step(1'b1, 64'hBCBC_0001, 1'b1, 4'b0000, '0);
    step(1'b1, 64'hD000, 1'b0, 4'b1001, '0);
    step(1'b1, 64'hD000, 1'b0, 4'b0000, '0);
    step(1'b1, 64'hD000, 1'b0, 4'b0010, '0);
    step(1'b1, 64'hD000, 1'b0, 4'b0000, '0);
    step(1'b1, 64'hD000, 1'b0, 4'b0100, '0);
    step(1'b0, '0, 1'b0, '1, '0);

    // Grant and done on the same core in the same cycle.
    refill();
    step(1'b1, 64'hE000, 1'b0, '1, '0);
    dn = '0;
    dn[pick(0)] = 1'b1;
    step(1'b1, 64'hE001, 1'b0, '1, dn);
    step(1'b0, '0, 1'b0, '1, '0);

    // Completion pulse on a full core is dropped.
    refill();
    step(1'b0, '0, 1'b0, '1, 4'b0001);

    // Asynchronous reset with two broadcast deliveries still outstanding.
    step(1'b1, 64'hF00D, 1'b1, 4'b0000, '0);
    step(1'b0, '0, 1'b0, 4'b0101, '0);
    #2;
    rst_n = 1'b0;
    done  = '1;
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("dut%0d async reset out_valid", m), data_t'(ov[m]), '0);
      check($sformatf("dut%0d async reset credits", m), data_t'(cr[m]), data_t'(full));
      check($sformatf("dut%0d async reset busy", m), data_t'(bz[m]), '0);
    end
    model_reset();
    @(posedge clk);
    #1;
    done  = '0;
    rst_n = 1'b1;
    step(1'b1, 64'h1234, 1'b0, '1, '0);
    step(1'b0, '0, 1'b0, '1, '0);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      dn = '0;
      for (int i = 0; i < N; i++)
        if (cred[0][i] < MAXC && cred[1][i] < MAXC && ($urandom_range(2) == 0)) dn[i] = 1'b1;
      rd = {$urandom, $urandom};
      step(($urandom_range(3) != 0), rd, ($urandom_range(7) == 0),
           N'($urandom | $urandom), dn);
    end
    repeat (4) step(1'b0, '0, 1'b0, '1, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
